// File: rtl/selector_sequencer.sv
// Debounced pushbutton mode selector: a two-flop synchroniser feeds a debounce FSM.
// Each accepted press steps selector_out with wrap-around; a host load takes priority.
module selector_sequencer #(
  parameter int WIDTH           = 2,
  parameter int NUM_MODES       = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] selector_out,
  output logic             changed,
  output logic             pressed
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_e;

  localparam int               CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST    = CW'(DEBOUNCE_CYCLES);
  localparam logic [WIDTH:0]   MODES_LIMIT = (WIDTH + 1)'(NUM_MODES);
  localparam logic [WIDTH-1:0] SEL_MAX     = WIDTH'(NUM_MODES - 1);
  localparam logic [WIDTH-1:0] SEL_ONE     = WIDTH'(1);

  logic             sync1_q, btn_sync_q;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] selector_q, selector_d;
  logic             changed_q, changed_d;
  logic             pressed_q, pressed_d;
  logic             accept;
  logic             load_ok;

  // State register, synchroniser and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      btn_sync_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      selector_q <= '0;
      changed_q  <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      sync1_q    <= button_in;
      btn_sync_q <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      selector_q <= selector_d;
      changed_q  <= changed_d;
      pressed_q  <= pressed_d;
    end
  end

  // Next-state logic; accept marks the cycle a press is qualified.
  // NOTE: every comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            accept  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = ARMING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      ARMING: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE == CNT_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_sync_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASING: begin
        if (btn_sync_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q + CNT_ONE == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: a valid load overrides a same-cycle press increment.
  always_comb begin
    load_ok    = load_en && ({1'b0, load_value} < MODES_LIMIT);
    selector_d = selector_q;
    if (load_ok) begin
      selector_d = load_value;
    end else if (accept) begin
      selector_d = (selector_q == SEL_MAX) ? '0 : selector_q + SEL_ONE;
    end
    changed_d = (selector_d != selector_q);
    pressed_d = (state_d == HELD) || (state_d == RELEASING);
  end

  assign selector_out = selector_q;
  assign changed      = changed_q;
  assign pressed      = pressed_q;

endmodule

// File: tb/tb_selector_sequencer.sv
// Directed bench for selector_sequencer: latency, wrap, bounce rejection, loads,
// load/press collision and asynchronous reset, with hand-computed expectations.
module tb_selector_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button_in = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] load_value = 2'd0;
  logic [1:0] selector_out;
  logic       changed, pressed;

  logic       m3_load_en = 1'b0;
  logic [1:0] m3_load_value = 2'd0;
  logic       m3_button = 1'b0;
  logic [1:0] m3_selector;
  logic       m3_changed, m3_pressed;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  selector_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .button_in   (button_in),
    .load_en     (load_en),
    .load_value  (load_value),
    .selector_out(selector_out),
    .changed     (changed),
    .pressed     (pressed)
  );

  selector_sequencer #(.WIDTH(2), .NUM_MODES(3), .DEBOUNCE_CYCLES(4)) dut_m3 (
    .clk         (clk),
    .reset       (reset),
    .button_in   (m3_button),
    .load_en     (m3_load_en),
    .load_value  (m3_load_value),
    .selector_out(m3_selector),
    .changed     (m3_changed),
    .pressed     (m3_pressed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Full clean press and release; exactly one changed pulse expected.
  task automatic do_press(input logic [1:0] exp_sel, input string tag);
    int pulses;
    pulses = 0;
    button_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (changed) pulses++;
    end
    button_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (changed) pulses++;
    end
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_sel"}, selector_out, exp_sel);
    check({tag, "_pressed"}, pressed, 0);
  endtask

  initial begin
    int pulses;
    int press_seen;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_sel", selector_out, 0);
    check("rst_changed", changed, 0);
    check("rst_pressed", pressed, 0);
    tick();
    tick();
    reset = 1'b0;

    // Single long press: update at edge 6, release completes at edge 16
    button_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check($sformatf("hold_sel_e%0d", e), selector_out, (e >= 6) ? 1 : 0);
      check($sformatf("hold_chg_e%0d", e), changed, (e == 6) ? 1 : 0);
      check($sformatf("hold_prs_e%0d", e), pressed, (e >= 6) ? 1 : 0);
    end
    button_in = 1'b0;
    for (int e = 11; e <= 18; e++) begin
      tick();
      check($sformatf("rel_prs_e%0d", e), pressed, (e < 16) ? 1 : 0);
      check($sformatf("rel_chg_e%0d", e), changed, 0);
    end
    check("rel_sel", selector_out, 1);

    // Four presses from reset wrap 1,2,3,0
    apply_reset();
    do_press(2'd1, "wrap1");
    do_press(2'd2, "wrap2");
    do_press(2'd3, "wrap3");
    do_press(2'd0, "wrap0");

    // Bounce never reaches four consecutive samples
    pulses = 0;
    press_seen = 0;
    button_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (changed) pulses++;
      if (pressed) press_seen++;
    end
    button_in = 1'b0;
    tick();
    if (changed) pulses++;
    if (pressed) press_seen++;
    button_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (changed) pulses++;
      if (pressed) press_seen++;
    end
    button_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (changed) pulses++;
      if (pressed) press_seen++;
    end
    check("bounce_pulses", pulses, 0);
    check("bounce_pressed", press_seen, 0);
    check("bounce_sel", selector_out, 0);
    do_press(2'd1, "after_bounce");

    // Loads: new value pulses changed, repeat value does not
    load_en = 1'b1;
    load_value = 2'd2;
    tick();
    check("load2_sel", selector_out, 2);
    check("load2_chg", changed, 1);
    tick();
    check("reload2_sel", selector_out, 2);
    check("reload2_chg", changed, 0);
    load_value = 2'd1;
    tick();
    check("load1_sel", selector_out, 1);
    check("load1_chg", changed, 1);
    load_value = 2'd3;
    tick();
    check("load3_sel", selector_out, 3);
    check("load3_chg", changed, 1);
    load_en = 1'b0;
    tick();
    check("load_idle_sel", selector_out, 3);
    check("load_idle_chg", changed, 0);

    // NUM_MODES=3 instance ignores load_value=3
    m3_load_en = 1'b1;
    m3_load_value = 2'd1;
    tick();
    check("m3_load1_sel", m3_selector, 1);
    check("m3_load1_chg", m3_changed, 1);
    m3_load_value = 2'd3;
    tick();
    check("m3_load3_sel", m3_selector, 1);
    check("m3_load3_chg", m3_changed, 0);
    m3_load_value = 2'd2;
    tick();
    check("m3_load2_sel", m3_selector, 2);
    check("m3_load2_chg", m3_changed, 1);
    m3_load_en = 1'b0;

    // Load collides with press accept: load wins, FSM still reaches HELD
    load_en = 1'b1;
    load_value = 2'd1;
    tick();
    load_en = 1'b0;
    tick();
    check("col_pre_sel", selector_out, 1);
    button_in = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("col_e5_sel", selector_out, 1);
    check("col_e5_prs", pressed, 0);
    load_en = 1'b1;
    load_value = 2'd3;
    tick();
    check("col_sel", selector_out, 3);
    check("col_chg", changed, 1);
    check("col_prs", pressed, 1);
    load_en = 1'b0;
    tick();
    check("col_next_sel", selector_out, 3);
    check("col_next_chg", changed, 0);
    button_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("col_rel_prs", pressed, 0);
    check("col_rel_sel", selector_out, 3);

    // Async reset mid-ARMING with a non-zero selector
    load_en = 1'b1;
    load_value = 2'd2;
    tick();
    load_en = 1'b0;
    button_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #2 reset = 1'b1;
    #1;
    check("arst_sel", selector_out, 0);
    check("arst_chg", changed, 0);
    check("arst_prs", pressed, 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("arst_e5_sel", selector_out, 0);
    tick();
    check("arst_e6_sel", selector_out, 1);
    check("arst_e6_chg", changed, 1);
    check("arst_e6_prs", pressed, 1);
    button_in = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("arst_rel_prs", pressed, 0);
    check("arst_rel_sel", selector_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
